// File: rtl/wb_stream_loader.sv
// Wishbone boot loader: packs a little-endian byte stream into 32-bit words
// and writes them to consecutive word addresses, with ack timeout and abort.
module wb_stream_loader #(
  parameter int ADDR_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  word_count_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [31:0]           wb_wdata_o,
  output logic                  wb_wr_en_o,
  output logic [3:0]            wb_byte_en_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic                  wb_ack_i
);

  localparam int TMO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  left_q, left_d;
  logic [31:0]           word_q, word_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            idx_q, idx_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  cyc_q, cyc_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  assign byte_ready_o = (state_q == COLLECT);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    error_d = error_q;

    if (abort_i) begin
      // Abort beats start, pending bytes and a same-cycle ack alike.
      state_d = IDLE;
      idx_d   = '0;
      word_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_d  = {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
            left_d  = word_count_i;
            error_d = 1'b0;
            idx_d   = '0;
            word_d  = '0;
            state_d = (word_count_i != '0) ? COLLECT : DONE;
          end
        end
        COLLECT: begin
          if (byte_valid_i) begin
            word_d[8*idx_q +: 8] = byte_i;
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              wdata_d = word_d;
              tmo_d   = '0;
              state_d = WRITE;
            end
          end
        end
        WRITE: begin
          if (wb_ack_i) begin
            addr_d  = addr_q + ADDR_WIDTH'(4);
            left_d  = left_q - CNT_WIDTH'(1);
            state_d = (left_q != CNT_WIDTH'(1)) ? COLLECT : DONE;
          end else if (tmo_q == TMO_LAST) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Registered outputs are decoded from the state being entered.
    cyc_d  = (state_d == WRITE);
    busy_d = (state_d == COLLECT) || (state_d == WRITE);
    done_d = (state_q == DONE) && !abort_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign wb_addr_o    = addr_q;
  assign wb_wdata_o   = wdata_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_wr_en_o   = cyc_q;
  assign wb_byte_en_o = {4{cyc_q}};

endmodule

// File: tb/tb_wb_stream_loader.sv
// Self-checking bench for wb_stream_loader: a byte feeder and a WB slave with
// programmable ack latency, checked against a word-level reference model.
module tb_wb_stream_loader;

  localparam int AW  = 32;
  localparam int CW  = 16;
  localparam int TMO = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i, abort_i;
  logic [AW-1:0] base_addr_i;
  logic [CW-1:0] word_count_i;
  logic [7:0]    byte_i;
  logic          byte_valid_i, byte_ready_o;
  logic          busy_o, done_o, error_o;
  logic [AW-1:0] wb_addr_o;
  logic [31:0]   wb_wdata_o;
  logic          wb_wr_en_o, wb_stb_o, wb_cyc_o, wb_ack_i;
  logic [3:0]    wb_byte_en_o;

  wb_stream_loader #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .ACK_TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .base_addr_i(base_addr_i), .word_count_i(word_count_i),
    .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .wb_addr_o(wb_addr_o), .wb_wdata_o(wb_wdata_o), .wb_wr_en_o(wb_wr_en_o),
    .wb_byte_en_o(wb_byte_en_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  byte_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          ack_delay  = 0;
  int          stb_cycles = 0;
  int          done_cnt   = 0;

  // Byte source: ready only changes after posedge, so a negedge handshake decision is safe.
  initial begin
    byte_valid_i = 1'b0;
    byte_i       = '0;
    forever begin
      @(negedge clk_i);
      if (byte_q.size() > 0) begin
        byte_valid_i = 1'b1;
        byte_i       = byte_q[0];
        if (byte_ready_o) void'(byte_q.pop_front());
      end else begin
        byte_valid_i = 1'b0;
        byte_i       = '0;
      end
    end
  end

  // WB slave: acks on the (ack_delay+1)-th strobe cycle; a negative delay never acks.
  initial begin
    int          wait_cnt = 0;
    bit          in_burst = 0;
    logic [31:0] hold_addr, hold_data;
    wb_ack_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (done_o) done_cnt++;
      if (wb_cyc_o) begin
        stb_cycles++;
        check("wb_stb", wb_stb_o, 1);
        check("wb_we", wb_wr_en_o, 1);
        check("wb_be", wb_byte_en_o, 4'hF);
        check("ready_in_write", byte_ready_o, 0);
        if (in_burst) begin
          check("addr_stable", wb_addr_o, hold_addr);
          check("data_stable", wb_wdata_o, hold_data);
        end
        in_burst  = 1;
        hold_addr = wb_addr_o;
        hold_data = wb_wdata_o;
        if (wait_cnt == ack_delay) begin
          wb_ack_i = 1'b1;
          wr_addr_q.push_back(wb_addr_o);
          wr_data_q.push_back(wb_wdata_o);
          wait_cnt = 0;
          in_burst = 0;
        end else begin
          wb_ack_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        check("wb_quiet", {wb_stb_o, wb_wr_en_o, wb_byte_en_o}, 0);
        wb_ack_i = 1'b0;
        wait_cnt = 0;
        in_burst = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic void rand_bytes(input int n, output logic [7:0] b[$]);
    b = {};
    for (int i = 0; i < n; i++) b.push_back(8'($urandom));
  endfunction

  task automatic pulse_start(input logic [31:0] base, input int count);
    @(negedge clk_i);
    base_addr_i  = base;
    word_count_i = CW'(count);
    start_i      = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Reference: word i lands at the aligned base plus 4*i, bytes packed little-endian.
  task automatic run_xfer(input string tag, input logic [31:0] base, input int count,
                          input int delay, input logic [7:0] bytes[$]);
    logic [31:0] exp_addr, exp_data;
    ack_delay = delay;
    wr_addr_q = {};
    wr_data_q = {};
    done_cnt  = 0;
    foreach (bytes[i]) byte_q.push_back(bytes[i]);
    pulse_start(base, count);
    check({tag, "_err_clear"}, error_o, 0);
    for (int i = 0; i < 4000 && done_cnt == 0; i++) @(negedge clk_i);
    repeat (2) @(negedge clk_i);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_nwrites"}, wr_addr_q.size(), count);
    for (int i = 0; i < count; i++) begin
      exp_addr = (base & 32'hFFFF_FFFC) + 32'(4 * i);
      exp_data = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
      if (i < wr_addr_q.size()) begin
        check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], exp_addr);
        check($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_data);
      end
    end
    check({tag, "_bytes_left"}, byte_q.size(), 0);
    check({tag, "_busy_end"}, busy_o, 0);
  endtask

  initial begin
    logic [7:0]  b[$];
    logic [31:0] rbase;
    int          rcnt;
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    base_addr_i  = '0;
    word_count_i = '0;
    #1;
    check("rst_flags", {busy_o, done_o, error_o, wb_cyc_o, wb_stb_o, wb_wr_en_o,
                        wb_byte_en_o, byte_ready_o}, 0);
    check("rst_addr", wb_addr_o, 0);
    check("rst_wdata", wb_wdata_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed two-word transfer with ack one cycle after strobe.
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_xfer("basic", 32'h0010_0000, 2, 1, b);

    // Zero words: done two cycles after start, no bus activity.
    stb_cycles = 0;
    done_cnt   = 0;
    pulse_start(32'h0000_1234, 0);
    check("zero_done_early", done_o, 0);
    @(negedge clk_i);
    check("zero_done_pulse", done_o, 1);
    @(negedge clk_i);
    check("zero_done_low", done_o, 0);
    repeat (3) @(negedge clk_i);
    check("zero_no_cyc", stb_cycles, 0);
    check("zero_done_cnt", done_cnt, 1);

    // Ack never returned: strobe held exactly ACK_TIMEOUT cycles, then error.
    ack_delay  = -1;
    stb_cycles = 0;
    done_cnt   = 0;
    wr_addr_q  = {};
    rand_bytes(4, b);
    foreach (b[i]) byte_q.push_back(b[i]);
    pulse_start(32'h0000_0400, 1);
    for (int i = 0; i < 100 && busy_o; i++) @(negedge clk_i);
    check("tmo_stb_cycles", stb_cycles, TMO);
    check("tmo_error", error_o, 1);
    check("tmo_cyc_low", wb_cyc_o, 0);
    repeat (3) @(negedge clk_i);
    check("tmo_no_done", done_cnt, 0);
    check("tmo_error_sticky", error_o, 1);

    // Next start clears the error; ack on the last allowed cycle still succeeds.
    rand_bytes(4, b);
    run_xfer("ack_at_limit", 32'h0000_0500, 1, TMO - 1, b);

    // Slow ack with bytes waiting: strobe stable, ready low, nothing lost.
    rand_bytes(12, b);
    run_xfer("slow_ack", 32'h0000_2000, 3, 5, b);

    // Abort after two bytes of the first word.
    ack_delay = 0;
    wr_addr_q = {};
    done_cnt  = 0;
    rand_bytes(2, b);
    foreach (b[i]) byte_q.push_back(b[i]);
    pulse_start(32'h0000_0100, 2);
    for (int i = 0; i < 20 && byte_q.size() > 0; i++) @(negedge clk_i);
    @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_ready", byte_ready_o, 0);
    repeat (3) @(negedge clk_i);
    check("abort_no_write", wr_addr_q.size(), 0);
    check("abort_no_done", done_cnt, 0);
    rand_bytes(4, b);
    run_xfer("restart", 32'h0000_0020, 1, 1, b);

    // Misaligned base near the top of the address space wraps to zero.
    rand_bytes(8, b);
    run_xfer("wrap", 32'hFFFF_FFFF, 2, 2, b);

    for (int r = 0; r < 6; r++) begin
      rbase = $urandom;
      rcnt  = $urandom_range(1, 4);
      rand_bytes(4 * rcnt, b);
      run_xfer($sformatf("rand%0d", r), rbase, rcnt, $urandom_range(0, TMO - 1), b);
    end

    // Asynchronous reset in the middle of a bus cycle.
    ack_delay = -1;
    rand_bytes(4, b);
    foreach (b[i]) byte_q.push_back(b[i]);
    pulse_start(32'h0000_0080, 1);
    for (int i = 0; i < 20 && !wb_cyc_o; i++) @(negedge clk_i);
    check("mid_rst_cyc_up", wb_cyc_o, 1);
    #1 rst_ni = 1'b0;
    #1;
    check("mid_rst_flags", {busy_o, error_o, wb_cyc_o, wb_stb_o, wb_byte_en_o}, 0);
    check("mid_rst_addr", wb_addr_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
